// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access sizes, FSM encoding and the
// byte-enable helper used by the store path.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Byte lanes touched by an access of the given size at the given lane offset.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_dm_if.sv
// Bus between the E/M register / hazard unit and the MEM stage.
// Handshake: stall = 1 means the stage is busy with the access presented on
// the inputs; upstream must hold every input stable until a cycle in which
// stall = 0, and that cycle's posedge is the one on which the access commits.
interface mem_stage_dm_if
  import mem_pkg::*;
#(
  parameter int AW_W = 5
) ();
  logic            valid_in;
  logic            flush;
  logic            mem_write;
  logic            mem_read;
  logic [1:0]      mem_size;
  logic            load_unsigned;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic            forward_sel;
  logic [31:0]     fwd_data;
  logic [31:0]     pc_in;
  logic            reg_write_in;
  logic [1:0]      mem_to_reg_in;
  logic [AW_W-1:0] awrite_in;
  logic [1:0]      tnew_in;

  logic            stall;
  logic            valid_out;
  logic [31:0]     rdata_out;
  logic [31:0]     alu_out;
  logic            reg_write_out;
  logic [1:0]      mem_to_reg_out;
  logic [AW_W-1:0] awrite_out;
  logic [1:0]      tnew_out;
  logic [31:0]     pc_out;
  logic            exc;
  state_t          state_dbg;

  modport master (
    output valid_in, flush, mem_write, mem_read, mem_size, load_unsigned, addr,
           wdata, forward_sel, fwd_data, pc_in, reg_write_in, mem_to_reg_in,
           awrite_in, tnew_in,
    input  stall, valid_out, rdata_out, alu_out, reg_write_out, mem_to_reg_out,
           awrite_out, tnew_out, pc_out, exc, state_dbg
  );

  modport slave (
    input  valid_in, flush, mem_write, mem_read, mem_size, load_unsigned, addr,
           wdata, forward_sel, fwd_data, pc_in, reg_write_in, mem_to_reg_in,
           awrite_in, tnew_in,
    output stall, valid_out, rdata_out, alu_out, reg_write_out, mem_to_reg_out,
           awrite_out, tnew_out, pc_out, exc, state_dbg
  );
endinterface

// File: rtl/mem_byte_ram.sv
// Word-organised data memory with per-byte write enables, synchronous write
// and combinational read. Contents are not reset.
module mem_byte_ram #(
  parameter int DEPTH_WORDS = 3072,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane masked write of the addressed word.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Indices past the end of the array read as zero instead of indexing out of bounds.
  assign rdata = (32'(idx) < 32'(DEPTH_WORDS)) ? mem[idx] : '0;
endmodule

// File: rtl/mem_stage_dm.sv
// MEM stage: data memory with sized loads/stores, optional wait states,
// alignment/range exceptions, flush, and the M/W pipeline register.
module mem_stage_dm
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 3072,
  parameter int WAIT_CYCLES = 0,
  parameter int AW_W        = 5
) (
  input  logic          clk,
  input  logic          reset,
  mem_stage_dm_if.slave bus
);
  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              access, is_load, exc_c, commit, stall_c;
  logic [1:0]        size_eff;
  logic [DATA_W-1:0] sd, wlanes, ram_word, word_sh, load_ext;
  logic [15:0]       half_sel;
  logic [3:0]        mem_we;

  logic              valid_q, valid_d, rw_q, rw_d, exc_q, exc_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, alu_q, alu_d, pc_q, pc_d;
  logic [1:0]        m2r_q, m2r_d, tnew_q, tnew_d;
  logic [AW_W-1:0]   aw_q, aw_d;

  // Decode the access, detect exceptions, build store lanes and extend load data.
  always_comb begin
    size_eff = (bus.mem_size == 2'b11) ? SZ_WORD : bus.mem_size;
    access   = bus.valid_in & (bus.mem_read | bus.mem_write);
    is_load  = bus.mem_read & ~bus.mem_write;
    exc_c    = ((size_eff == SZ_HALF) & bus.addr[0])
             | ((size_eff == SZ_WORD) & (bus.addr[1:0] != 2'b00))
             | ({1'b0, bus.addr} >= ADDR_LIMIT);
    sd       = bus.forward_sel ? bus.fwd_data : bus.wdata;
    case (size_eff)
      SZ_BYTE: wlanes = {4{sd[7:0]}};
      SZ_HALF: wlanes = {2{sd[15:0]}};
      default: wlanes = sd;
    endcase
    word_sh  = ram_word >> {bus.addr[1:0], 3'b000};
    half_sel = bus.addr[1] ? ram_word[31:16] : ram_word[15:0];
    case (size_eff)
      SZ_BYTE: load_ext = {{24{~bus.load_unsigned & word_sh[7]}}, word_sh[7:0]};
      SZ_HALF: load_ext = {{16{~bus.load_unsigned & half_sel[15]}}, half_sel};
      default: load_ext = ram_word;
    endcase
    mem_we = (commit & access & bus.mem_write & ~exc_c) ? byte_en(size_eff, bus.addr[1:0]) : 4'b0000;
  end

  mem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .idx   (bus.addr[IDX_W+1:2]),
    .wdata (wlanes),
    .rdata (ram_word)
  );

  // Wait-state FSM: decides the commit edge and drives stall; flush wins over commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && WAIT_CYCLES > 0) begin
          state_d = WAIT;
          cnt_d   = 3'(WAIT_CYCLES - 1);
          stall_c = 1'b1;
        end else if (bus.valid_in) begin
          commit = 1'b1;
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          commit  = 1'b1;
          stall_c = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      commit  = 1'b0;
    end
  end

  // M/W register next value: full load on commit, bubble otherwise.
  always_comb begin
    valid_d = 1'b0;
    rw_d    = 1'b0;
    exc_d   = 1'b0;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    pc_d    = pc_q;
    m2r_d   = m2r_q;
    tnew_d  = tnew_q;
    aw_d    = aw_q;
    if (commit) begin
      valid_d = 1'b1;
      exc_d   = access & exc_c;
      rw_d    = bus.reg_write_in & ~(access & exc_c);
      rdata_d = (access & is_load & ~exc_c) ? load_ext : '0;
      alu_d   = bus.addr;
      pc_d    = bus.pc_in;
      m2r_d   = bus.mem_to_reg_in;
      aw_d    = bus.awrite_in;
      tnew_d  = (bus.tnew_in == 2'd0) ? 2'd0 : bus.tnew_in - 2'd1;
    end
  end

  // State and M/W register flops with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      exc_q   <= 1'b0;
      rdata_q <= '0;
      alu_q   <= '0;
      pc_q    <= '0;
      m2r_q   <= 2'd0;
      tnew_q  <= 2'd0;
      aw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rw_q    <= rw_d;
      exc_q   <= exc_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      pc_q    <= pc_d;
      m2r_q   <= m2r_d;
      tnew_q  <= tnew_d;
      aw_q    <= aw_d;
    end
  end

  // Stall drops as soon as reset is asserted, even if the inputs still request an access.
  assign bus.stall          = stall_c & reset;
  assign bus.valid_out      = valid_q;
  assign bus.rdata_out      = rdata_q;
  assign bus.alu_out        = alu_q;
  assign bus.reg_write_out  = rw_q;
  assign bus.mem_to_reg_out = m2r_q;
  assign bus.awrite_out     = aw_q;
  assign bus.tnew_out       = tnew_q;
  assign bus.pc_out         = pc_q;
  assign bus.exc            = exc_q;
  assign bus.state_dbg      = state_q;
endmodule

// File: tb/tb_mem_stage_dm.sv
// Bench for mem_stage_dm: three instances (0, 3 and 2 wait states) share one
// set of stimulus signals; en selects which instance sees valid_in/flush.
module tb_mem_stage_dm;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  en;
  logic        valid_in, flush, mem_write, mem_read, load_unsigned, forward_sel, reg_write_in;
  logic [1:0]  mem_size, mem_to_reg_in, tnew_in;
  logic [31:0] addr, wdata, fwd_data, pc_in;
  logic [4:0]  awrite_in;

  int checks = 0;
  int failures = 0;

  mem_stage_dm_if #(.AW_W(5)) if0 ();
  mem_stage_dm_if #(.AW_W(5)) if3 ();
  mem_stage_dm_if #(.AW_W(5)) if2 ();

  mem_stage_dm #(.WAIT_CYCLES(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
  mem_stage_dm #(.WAIT_CYCLES(3)) u3 (.clk(clk), .reset(reset), .bus(if3));
  mem_stage_dm #(.WAIT_CYCLES(2)) u2 (.clk(clk), .reset(reset), .bus(if2));

  // Fan the shared stimulus out to all three instances.
  always_comb begin
    if0.valid_in = valid_in & en[0]; if0.flush = flush & en[0]; if0.mem_write = mem_write; if0.mem_read = mem_read;
    if0.mem_size = mem_size; if0.load_unsigned = load_unsigned; if0.addr = addr; if0.wdata = wdata;
    if0.forward_sel = forward_sel; if0.fwd_data = fwd_data; if0.pc_in = pc_in; if0.reg_write_in = reg_write_in;
    if0.mem_to_reg_in = mem_to_reg_in; if0.awrite_in = awrite_in; if0.tnew_in = tnew_in;
    if3.valid_in = valid_in & en[1]; if3.flush = flush & en[1]; if3.mem_write = mem_write; if3.mem_read = mem_read;
    if3.mem_size = mem_size; if3.load_unsigned = load_unsigned; if3.addr = addr; if3.wdata = wdata;
    if3.forward_sel = forward_sel; if3.fwd_data = fwd_data; if3.pc_in = pc_in; if3.reg_write_in = reg_write_in;
    if3.mem_to_reg_in = mem_to_reg_in; if3.awrite_in = awrite_in; if3.tnew_in = tnew_in;
    if2.valid_in = valid_in & en[2]; if2.flush = flush & en[2]; if2.mem_write = mem_write; if2.mem_read = mem_read;
    if2.mem_size = mem_size; if2.load_unsigned = load_unsigned; if2.addr = addr; if2.wdata = wdata;
    if2.forward_sel = forward_sel; if2.fwd_data = fwd_data; if2.pc_in = pc_in; if2.reg_write_in = reg_write_in;
    if2.mem_to_reg_in = mem_to_reg_in; if2.awrite_in = awrite_in; if2.tnew_in = tnew_in;
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic        fsel;
    logic [31:0] fwd;
    logic [1:0]  tnew;
    logic [31:0] exp_rd;
    logic        exp_exc;
    logic [1:0]  exp_tnew;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd, input logic fsel,
                              input logic [31:0] fwd, input logic [1:0] tnew, input logic [31:0] exp_rd,
                              input logic exp_exc, input logic [1:0] exp_tnew);
    vec_t v;
    v.wr = wr; v.rd = rd; v.sz = sz; v.uns = uns; v.a = a; v.wd = wd; v.fsel = fsel; v.fwd = fwd;
    v.tnew = tnew; v.exp_rd = exp_rd; v.exp_exc = exp_exc; v.exp_tnew = exp_tnew;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 1'b0; flush = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
  endtask

  task automatic set_acc(input logic wr, input logic rd, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
    valid_in = 1'b1; flush = 1'b0; mem_write = wr; mem_read = rd; mem_size = sz;
    load_unsigned = 1'b0; addr = a; wdata = wd; forward_sel = 1'b0; fwd_data = 32'h0;
    pc_in = 32'h0000_0100; reg_write_in = 1'b1; mem_to_reg_in = 2'd1; awrite_in = 5'd7; tnew_in = 2'd2;
    #1;
  endtask

  initial begin
    vec_t v;
    en = 3'b000;
    idle();
    mem_size = SZ_WORD; load_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0; forward_sel = 1'b0;
    fwd_data = 32'h0; pc_in = 32'h0; reg_write_in = 1'b0; mem_to_reg_in = 2'd0; awrite_in = 5'd0; tnew_in = 2'd0;

    // wr rd size uns addr wdata fsel fwd tnew exp_rdata exp_exc exp_tnew
    vecs.push_back(mk(1, 0, SZ_WORD, 0, 32'h10,   32'h8badf00d, 0, 0,            2'd2, 32'h0,        0, 2'd1));
    vecs.push_back(mk(0, 1, SZ_WORD, 0, 32'h10,   32'h0,        0, 0,            2'd0, 32'h8badf00d, 0, 2'd0));
    vecs.push_back(mk(1, 0, SZ_WORD, 0, 32'h20,   32'h0,        0, 0,            2'd1, 32'h0,        0, 2'd0));
    vecs.push_back(mk(1, 0, SZ_BYTE, 0, 32'h21,   32'h000000f0, 0, 0,            2'd3, 32'h0,        0, 2'd2));
    vecs.push_back(mk(0, 1, SZ_BYTE, 0, 32'h21,   32'h0,        0, 0,            2'd2, 32'hfffffff0, 0, 2'd1));
    vecs.push_back(mk(0, 1, SZ_BYTE, 1, 32'h21,   32'h0,        0, 0,            2'd2, 32'h000000f0, 0, 2'd1));
    vecs.push_back(mk(0, 1, SZ_WORD, 0, 32'h20,   32'h0,        0, 0,            2'd2, 32'h0000f000, 0, 2'd1));
    vecs.push_back(mk(1, 0, SZ_HALF, 0, 32'h12,   32'h0,        1, 32'h1234abcd, 2'd2, 32'h0,        0, 2'd1));
    vecs.push_back(mk(0, 1, SZ_HALF, 1, 32'h12,   32'h0,        0, 0,            2'd2, 32'h0000abcd, 0, 2'd1));
    vecs.push_back(mk(0, 1, SZ_HALF, 0, 32'h12,   32'h0,        0, 0,            2'd2, 32'hffffabcd, 0, 2'd1));
    vecs.push_back(mk(0, 1, SZ_HALF, 0, 32'h10,   32'h0,        0, 0,            2'd2, 32'hfffff00d, 0, 2'd1));
    vecs.push_back(mk(0, 1, SZ_HALF, 1, 32'h10,   32'h0,        0, 0,            2'd2, 32'h0000f00d, 0, 2'd1));
    vecs.push_back(mk(1, 0, SZ_WORD, 0, 32'h13,   32'hdeadbeef, 0, 0,            2'd2, 32'h0,        1, 2'd1));
    vecs.push_back(mk(0, 1, SZ_WORD, 0, 32'h3000, 32'h0,        0, 0,            2'd2, 32'h0,        1, 2'd1));
    vecs.push_back(mk(1, 0, SZ_WORD, 0, 32'h2ffc, 32'h11223344, 0, 0,            2'd2, 32'h0,        0, 2'd1));
    vecs.push_back(mk(0, 1, SZ_WORD, 0, 32'h2ffc, 32'h0,        0, 0,            2'd2, 32'h11223344, 0, 2'd1));
    vecs.push_back(mk(0, 1, SZ_HALF, 0, 32'h11,   32'h0,        0, 0,            2'd2, 32'h0,        1, 2'd1));
    vecs.push_back(mk(0, 1, SZ_BYTE, 0, 32'h13,   32'h0,        0, 0,            2'd2, 32'hffffffab, 0, 2'd1));
    vecs.push_back(mk(0, 1, SZ_WORD, 0, 32'h10,   32'h0,        0, 0,            2'd2, 32'habcdf00d, 0, 2'd1));
    vecs.push_back(mk(1, 1, SZ_WORD, 0, 32'h24,   32'h00000077, 0, 0,            2'd2, 32'h0,        0, 2'd1));
    vecs.push_back(mk(0, 1, SZ_WORD, 0, 32'h24,   32'h0,        0, 0,            2'd2, 32'h00000077, 0, 2'd1));
    vecs.push_back(mk(0, 1, 2'b11,   0, 32'h10,   32'h0,        0, 0,            2'd2, 32'habcdf00d, 0, 2'd1));
    vecs.push_back(mk(0, 0, SZ_WORD, 0, 32'h5000, 32'h0,        0, 0,            2'd2, 32'h0,        0, 2'd1));
    vecs.push_back(mk(1, 0, SZ_BYTE, 0, 32'h22,   32'h12345678, 0, 0,            2'd2, 32'h0,        0, 2'd1));
    vecs.push_back(mk(0, 1, SZ_WORD, 0, 32'h20,   32'h0,        0, 0,            2'd2, 32'h0078f000, 0, 2'd1));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, if0.valid_out}, 32'h0);
    check("rst_rdata", if0.rdata_out, 32'h0);
    check("rst_alu", if0.alu_out, 32'h0);
    check("rst_rw", {31'b0, if0.reg_write_out}, 32'h0);
    check("rst_m2r", {30'b0, if0.mem_to_reg_out}, 32'h0);
    check("rst_aw", {27'b0, if0.awrite_out}, 32'h0);
    check("rst_tnew", {30'b0, if0.tnew_out}, 32'h0);
    check("rst_pc", if0.pc_out, 32'h0);
    check("rst_exc", {31'b0, if0.exc}, 32'h0);
    check("rst_stall", {31'b0, if0.stall}, 32'h0);
    reset = 1'b1;
    step();

    // Table-driven vectors on the zero-wait instance, issued back to back.
    en = 3'b001;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      valid_in = 1'b1; flush = 1'b0; mem_write = v.wr; mem_read = v.rd; mem_size = v.sz;
      load_unsigned = v.uns; addr = v.a; wdata = v.wd; forward_sel = v.fsel; fwd_data = v.fwd;
      pc_in = 32'h0040_0000 + 32'(4 * i); reg_write_in = 1'b1; mem_to_reg_in = 2'(i);
      awrite_in = 5'(i); tnew_in = v.tnew;
      #1;
      check($sformatf("v%0d_stall", i), {31'b0, if0.stall}, 32'h0);
      step();
      check($sformatf("v%0d_valid", i), {31'b0, if0.valid_out}, 32'h1);
      check($sformatf("v%0d_rdata", i), if0.rdata_out, v.exp_rd);
      check($sformatf("v%0d_exc", i), {31'b0, if0.exc}, {31'b0, v.exp_exc});
      check($sformatf("v%0d_rw", i), {31'b0, if0.reg_write_out}, {31'b0, ~v.exp_exc});
      check($sformatf("v%0d_alu", i), if0.alu_out, v.a);
      check($sformatf("v%0d_tnew", i), {30'b0, if0.tnew_out}, {30'b0, v.exp_tnew});
      check($sformatf("v%0d_pc", i), if0.pc_out, 32'h0040_0000 + 32'(4 * i));
      check($sformatf("v%0d_aw", i), {27'b0, if0.awrite_out}, 32'(i % 32));
      check($sformatf("v%0d_m2r", i), {30'b0, if0.mem_to_reg_out}, 32'(i % 4));
    end
    idle();
    step();
    check("w0_idle_bubble", {31'b0, if0.valid_out}, 32'h0);

    // Three wait states: store, then load with stall and bubble pattern.
    en = 3'b010;
    set_acc(1'b1, 1'b0, SZ_WORD, 32'h8, 32'hcafef00d);
    repeat (4) step();
    check("w3_sw_valid", {31'b0, if3.valid_out}, 32'h1);
    set_acc(1'b0, 1'b1, SZ_WORD, 32'h8, 32'h0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("w3_stall%0d", k), {31'b0, if3.stall}, (k < 3) ? 32'h1 : 32'h0);
      step();
      check($sformatf("w3_valid%0d", k), {31'b0, if3.valid_out}, (k == 3) ? 32'h1 : 32'h0);
    end
    check("w3_rdata", if3.rdata_out, 32'hcafef00d);
    idle();
    step();
    check("w3_after_valid", {31'b0, if3.valid_out}, 32'h0);

    // Two wait states: flush on the commit cycle suppresses the store.
    en = 3'b100;
    set_acc(1'b1, 1'b0, SZ_WORD, 32'h40, 32'h0000aaaa);
    repeat (3) step();
    check("w2_sw_valid", {31'b0, if2.valid_out}, 32'h1);
    set_acc(1'b1, 1'b0, SZ_WORD, 32'h40, 32'h00000055);
    step();
    step();
    check("w2_last_stall", {31'b0, if2.stall}, 32'h0);
    flush = 1'b1;
    step();
    idle();
    check("w2_flush_valid", {31'b0, if2.valid_out}, 32'h0);
    check("w2_flush_state", {31'b0, if2.state_dbg}, {31'b0, IDLE});
    set_acc(1'b0, 1'b1, SZ_WORD, 32'h40, 32'h0);
    repeat (3) step();
    check("w2_lw_valid", {31'b0, if2.valid_out}, 32'h1);
    check("w2_lw_rdata", if2.rdata_out, 32'h0000aaaa);

    // Reset in the middle of a store's wait states.
    set_acc(1'b1, 1'b0, SZ_WORD, 32'h40, 32'h00000099);
    step();
    check("w2_mid_stall", {31'b0, if2.stall}, 32'h1);
    reset = 1'b0;
    #1;
    check("w2_rst_stall", {31'b0, if2.stall}, 32'h0);
    check("w2_rst_valid", {31'b0, if2.valid_out}, 32'h0);
    check("w2_rst_rdata", if2.rdata_out, 32'h0);
    check("w2_rst_alu", if2.alu_out, 32'h0);
    check("w2_rst_pc", if2.pc_out, 32'h0);
    check("w2_rst_tnew", {30'b0, if2.tnew_out}, 32'h0);
    check("w2_rst_state", {31'b0, if2.state_dbg}, {31'b0, IDLE});
    idle();
    #2;
    reset = 1'b1;
    step();
    set_acc(1'b0, 1'b1, SZ_WORD, 32'h40, 32'h0);
    repeat (3) step();
    check("w2_post_rst_valid", {31'b0, if2.valid_out}, 32'h1);
    check("w2_post_rst_rdata", if2.rdata_out, 32'h0000aaaa);
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
